// File: rtl/issue_scoreboard_pkg.sv
// Shared types and constants for the issue scoreboard.
//   sb_state_t : RUN / DRAIN / HALTED state of the stop/halt sequencer
//   reg_tag_t  : 6-bit register tag, bit 5 selects the fpr bank
//   RW_*       : writeback class encodings (2'b11 behaves as RW_NONE)
package issue_scoreboard_pkg;

  localparam int SB_NREG   = 64;
  localparam int SB_WAIT_W = 5;

  typedef enum logic [1:0] {SB_RUN, SB_DRAIN, SB_HALTED} sb_state_t;

  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_GPR  = 2'b01;
  localparam logic [1:0] RW_FPR  = 2'b10;

  typedef logic [5:0] reg_tag_t;

  // Only the gpr and fpr classes produce a result; 2'b11 is ignored.
  function automatic logic rw_writes(input logic [1:0] rw);
    return (rw == RW_GPR) || (rw == RW_FPR);
  endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode/execute-facing bundle of the issue scoreboard.
// Handshake: an instruction presented with id_valid=1 is consumed in the
// cycle where issue=1 (which already includes ex_ready); while stall=1 the
// decode side must hold the instruction stable. issue/stall are
// combinational in the same cycle; the remaining outputs are registered.
//   master : decode/execute side (drives instruction fields, ex_ready)
//   slave  : scoreboard side (drives issue, stall, busy, fpu_busy, halted,
//            dbg_state)
interface issue_scoreboard_if
  import issue_scoreboard_pkg::*;
#(
  parameter int NREG   = 64,
  parameter int WAIT_W = 5
);
  logic              id_valid;
  reg_tag_t          rs;
  reg_tag_t          rt;
  logic              use_s;
  logic              use_t;
  logic [1:0]        rw;
  logic [4:0]        rd;
  logic [WAIT_W-1:0] wait_time;
  logic              fpu_long;
  logic              stop;
  logic              ex_ready;
  logic              issue;
  logic              stall;
  logic [NREG-1:0]   busy;
  logic              fpu_busy;
  logic              halted;
  sb_state_t         dbg_state;

  modport master (
    output id_valid, rs, rt, use_s, use_t, rw, rd, wait_time, fpu_long, stop,
           ex_ready,
    input  issue, stall, busy, fpu_busy, halted, dbg_state
  );

  modport slave (
    input  id_valid, rs, rt, use_s, use_t, rw, rd, wait_time, fpu_long, stop,
           ex_ready,
    output issue, stall, busy, fpu_busy, halted, dbg_state
  );
endinterface

// File: rtl/issue_scoreboard_sb_counter.sv
// One countdown counter of the scoreboard (the sb_counter cell).
//   clk, rstn : clock, asynchronous active-low reset
//   i_load    : load i_val this cycle (wins over the decrement)
//   i_val     : value to load
//   o_nz      : counter is nonzero
module issue_scoreboard_sb_counter #(
  parameter int WAIT_W = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_load,
  input  logic [WAIT_W-1:0] i_val,
  output logic              o_nz
);
  logic [WAIT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - WAIT_W'(1);
    end
  end

  assign o_nz = (r_cnt != '0);
endmodule

// File: rtl/issue_scoreboard.sv
// Issue-stage scoreboard between decode and execute. Tracks one countdown
// per register tag plus one for the non-pipelined long FPU unit, stalls
// RAW/WAW/structural hazards and sequences the stop -> drain -> halt flow.
//   clk, rstn : clock, asynchronous active-low reset
//   sb        : issue_scoreboard_if.slave (instruction in, issue/stall,
//               busy vector, fpu_busy, halted, dbg_state out)
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int NREG   = 64,
  parameter int WAIT_W = 5
) (
  input  logic                clk,
  input  logic                rstn,
  issue_scoreboard_if.slave   sb
);
  logic            w_writes;
  reg_tag_t        w_dtag;
  logic [NREG-1:0] w_busy;
  logic [NREG-1:0] w_load;
  logic            w_fpu_busy;
  logic            w_hazard;
  logic            w_issue;
  logic            w_set;
  sb_state_t       r_state;
  logic            r_halted;

  assign w_writes = rw_writes(sb.rw);
  assign w_dtag   = {sb.rw == RW_FPR, sb.rd};

  // Counters are registered, so an instruction whose source equals its own
  // destination only sees the state left by earlier instructions.
  assign w_hazard = (sb.use_s    && w_busy[sb.rs])
                 || (sb.use_t    && w_busy[sb.rt])
                 || (w_writes    && w_busy[w_dtag])
                 || (sb.fpu_long && w_fpu_busy);

  assign w_issue = sb.id_valid && sb.ex_ready && !w_hazard
                && (r_state == SB_RUN);

  // Single-cycle results are covered by forwarding, so wait_time=0 sets
  // nothing.
  assign w_set = w_issue && w_writes && (sb.wait_time != '0);

  for (genvar g = 0; g < NREG; g++) begin : g_reg_cnt
    assign w_load[g] = w_set && (w_dtag == reg_tag_t'(g));

    issue_scoreboard_sb_counter #(.WAIT_W(WAIT_W)) u_cnt (
      .clk    (clk),
      .rstn   (rstn),
      .i_load (w_load[g]),
      .i_val  (sb.wait_time),
      .o_nz   (w_busy[g])
    );
  end

  issue_scoreboard_sb_counter #(.WAIT_W(WAIT_W)) u_fpu_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .i_load (w_issue && sb.fpu_long),
    .i_val  (sb.wait_time),
    .o_nz   (w_fpu_busy)
  );

  // Stop/halt sequencer. DRAIN exits only once every registered counter
  // has reached zero; HALTED is left only through reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= SB_RUN;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        SB_RUN: begin
          if (w_issue && sb.stop) r_state <= SB_DRAIN;
        end
        SB_DRAIN: begin
          if (!(|w_busy) && !w_fpu_busy) begin
            r_state  <= SB_HALTED;
            r_halted <= 1'b1;
          end
        end
        SB_HALTED: begin
          r_state <= SB_HALTED;
        end
        default: begin
          r_state  <= SB_RUN;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign sb.issue     = w_issue;
  assign sb.stall     = sb.id_valid && !w_issue;
  assign sb.busy      = w_busy;
  assign sb.fpu_busy  = w_fpu_busy;
  assign sb.halted    = r_halted;
  assign sb.dbg_state = r_state;
endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  localparam int NREG   = 64;
  localparam int WAIT_W = 5;

  logic clk;
  logic rstn;

  issue_scoreboard_if #(.NREG(NREG), .WAIT_W(WAIT_W)) sb_if ();

  issue_scoreboard #(.NREG(NREG), .WAIT_W(WAIT_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .sb   (sb_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [1:0] exp_q[$];   // {issue, stall}
  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [5:0] rs_i,
                       input logic [5:0] rt_i, input logic us, input logic ut,
                       input logic [1:0] rw_i, input logic [4:0] rd_i,
                       input logic [4:0] wt, input logic fl, input logic st);
    sb_if.id_valid  = v;
    sb_if.rs        = rs_i;
    sb_if.rt        = rt_i;
    sb_if.use_s     = us;
    sb_if.use_t     = ut;
    sb_if.rw        = rw_i;
    sb_if.rd        = rd_i;
    sb_if.wait_time = wt;
    sb_if.fpu_long  = fl;
    sb_if.stop      = st;
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, RW_NONE, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  // Expected handshake is queued with the stimulus, then popped and
  // compared once the combinational outputs have settled.
  task automatic expect_hs(input string tag, input logic ei, input logic es);
    logic [1:0] e;
    exp_q.push_back({ei, es});
    #2;
    e = exp_q.pop_front();
    check_val(tag, {62'd0, sb_if.issue, sb_if.stall}, {62'd0, e});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn = 1'b0;
    sb_if.ex_ready = 1'b1;
    idle();
    #23;
    check_val("rst_busy", sb_if.busy, 64'd0);
    check_val("rst_fpu_busy", sb_if.fpu_busy, 0);
    check_val("rst_halted", sb_if.halted, 0);
    rstn = 1'b1;

    // T1: load r3 wait=1, then dependent add on rs=3
    next_cycle();
    drive(1, 0, 0, 0, 0, RW_GPR, 5'd3, 5'd1, 0, 0);
    expect_hs("t1_load_c0", 1, 0);
    check_val("t1_busy3_c0", sb_if.busy[3], 0);
    next_cycle();
    drive(1, 6'd3, 0, 1, 0, RW_GPR, 5'd8, 5'd0, 0, 0);
    expect_hs("t1_dep_c1", 0, 1);
    check_val("t1_busy3_c1", sb_if.busy[3], 1);
    next_cycle();
    expect_hs("t1_dep_c2", 1, 0);
    check_val("t1_busy3_c2", sb_if.busy[3], 0);
    next_cycle();
    idle();
    expect_hs("t1_idle", 0, 0);
    check_val("t1_busy_all", sb_if.busy, 64'd0);

    // T2: FPU add f4 wait=5, dependent reads rt=f4 (tag 36)
    next_cycle();
    drive(1, 0, 0, 0, 0, RW_FPR, 5'd4, 5'd5, 1, 0);
    expect_hs("t2_fadd_c0", 1, 0);
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      drive(1, 0, 6'h24, 0, 1, RW_NONE, 5'd0, 5'd0, 0, 0);
      expect_hs($sformatf("t2_dep_c%0d", c), 0, 1);
      check_val($sformatf("t2_busy36_c%0d", c), sb_if.busy[36], 1);
    end
    next_cycle();
    expect_hs("t2_dep_c6", 1, 0);
    check_val("t2_busy36_c6", sb_if.busy[36], 0);
    check_val("t2_fpu_busy_c6", sb_if.fpu_busy, 0);

    // T3: two independent back-to-back long FPU ops
    next_cycle();
    drive(1, 0, 0, 0, 0, RW_FPR, 5'd10, 5'd5, 1, 0);
    expect_hs("t3_first", 1, 0);
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      drive(1, 0, 0, 0, 0, RW_FPR, 5'd11, 5'd5, 1, 0);
      expect_hs($sformatf("t3_second_c%0d", c), 0, 1);
      check_val($sformatf("t3_fpu_busy_c%0d", c), sb_if.fpu_busy, 1);
    end
    next_cycle();
    expect_hs("t3_second_c6", 1, 0);
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      idle();
    end
    check_val("t3_drained_busy", sb_if.busy, 64'd0);
    check_val("t3_drained_fpu", sb_if.fpu_busy, 0);

    // T4: WAW on r7, second writer has wait=0
    next_cycle();
    drive(1, 0, 0, 0, 0, RW_GPR, 5'd7, 5'd1, 0, 0);
    expect_hs("t4_load", 1, 0);
    next_cycle();
    drive(1, 0, 0, 0, 0, RW_GPR, 5'd7, 5'd0, 0, 0);
    expect_hs("t4_waw_c1", 0, 1);
    check_val("t4_busy7_c1", sb_if.busy[7], 1);
    next_cycle();
    expect_hs("t4_waw_c2", 1, 0);
    check_val("t4_busy7_c2", sb_if.busy[7], 0);
    next_cycle();
    idle();
    expect_hs("t4_idle", 0, 0);
    check_val("t4_busy7_c3", sb_if.busy[7], 0);

    // ex_ready=0 stall must not load a counter
    next_cycle();
    sb_if.ex_ready = 1'b0;
    drive(1, 0, 0, 0, 0, RW_GPR, 5'd9, 5'd3, 1, 0);
    expect_hs("exr_stall", 0, 1);
    next_cycle();
    sb_if.ex_ready = 1'b1;
    idle();
    expect_hs("exr_idle", 0, 0);
    check_val("exr_busy9", sb_if.busy[9], 0);
    check_val("exr_fpu_busy", sb_if.fpu_busy, 0);

    // Source equal to own destination does not stall itself
    next_cycle();
    drive(1, 6'd5, 0, 1, 0, RW_GPR, 5'd5, 5'd2, 0, 0);
    expect_hs("self_dep", 1, 0);
    next_cycle();
    idle();
    check_val("self_busy5_c1", sb_if.busy[5], 1);
    next_cycle();
    check_val("self_busy5_c2", sb_if.busy[5], 1);
    next_cycle();
    check_val("self_busy5_c3", sb_if.busy[5], 0);

    // rw=11 writes nothing; gpr 0 is tracked
    next_cycle();
    drive(1, 0, 0, 0, 0, 2'b11, 5'd12, 5'd3, 0, 0);
    expect_hs("rw11_issue", 1, 0);
    next_cycle();
    drive(1, 0, 0, 0, 0, RW_GPR, 5'd0, 5'd1, 0, 0);
    expect_hs("r0_issue", 1, 0);
    check_val("rw11_busy", sb_if.busy, 64'd0);
    next_cycle();
    idle();
    check_val("r0_busy", sb_if.busy, 64'd1);
    next_cycle();

    // T5: stop with hazard stalls, stop at cnt[36]=3 drains then halts
    next_cycle();
    drive(1, 0, 0, 0, 0, RW_FPR, 5'd4, 5'd4, 1, 0);
    expect_hs("t5_fpu", 1, 0);
    next_cycle();
    drive(1, 6'h24, 0, 1, 0, RW_NONE, 5'd0, 5'd0, 0, 1);
    expect_hs("t5_stop_haz", 0, 1);
    check_val("t5_state_run", sb_if.dbg_state, SB_RUN);
    next_cycle();
    drive(1, 0, 0, 0, 0, RW_NONE, 5'd0, 5'd0, 0, 1);
    expect_hs("t5_stop_issue", 1, 0);
    check_val("t5_busy36_3", sb_if.busy[36], 1);
    for (int c = 3; c <= 5; c++) begin
      next_cycle();
      drive(1, 0, 0, 0, 0, RW_GPR, 5'd1, 5'd0, 0, 0);
      expect_hs($sformatf("t5_drain_c%0d", c), 0, 1);
      check_val($sformatf("t5_halted_c%0d", c), sb_if.halted, 0);
    end
    check_val("t5_busy36_c5", sb_if.busy[36], 0);
    for (int c = 6; c <= 8; c++) begin
      next_cycle();
      expect_hs($sformatf("t5_halt_c%0d", c), 0, 1);
      check_val($sformatf("t5_halted_c%0d", c), sb_if.halted, 1);
    end

    // T6: reset mid-drain
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    next_cycle();
    drive(1, 0, 0, 0, 0, RW_FPR, 5'd4, 5'd10, 1, 0);
    expect_hs("t6_fpu", 1, 0);
    next_cycle();
    drive(1, 0, 0, 0, 0, RW_NONE, 5'd0, 5'd0, 0, 1);
    expect_hs("t6_stop", 1, 0);
    next_cycle();
    idle();
    expect_hs("t6_drain", 0, 0);
    check_val("t6_busy36_pre", sb_if.busy[36], 1);
    check_val("t6_fpu_busy_pre", sb_if.fpu_busy, 1);
    rstn = 1'b0;
    #1;
    check_val("t6_rst_busy", sb_if.busy, 64'd0);
    check_val("t6_rst_fpu_busy", sb_if.fpu_busy, 0);
    check_val("t6_rst_halted", sb_if.halted, 0);
    drive(1, 0, 0, 0, 0, RW_GPR, 5'd2, 5'd0, 0, 0);
    #1;
    check_val("t6_rst_issue", {sb_if.issue, sb_if.stall}, 2'b10);
    rstn = 1'b1;
    next_cycle();
    drive(1, 0, 0, 0, 0, RW_GPR, 5'd1, 5'd0, 0, 0);
    expect_hs("t6_after_rst", 1, 0);
    next_cycle();
    idle();
    check_val("t6_halted_end", sb_if.halted, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
